// File: rtl/wisc15_pkg.sv
// Shared WISC-15 pipeline definitions: instruction encodings, widths and the
// fetch-stage state type used by fetch, decode and hazard detect.
package wisc15_pkg;

  localparam int          INSTR_W    = 16;
  localparam int          REG_ADDR_W = 4;
  localparam logic [3:0]  OP_HLT     = 4'hF;
  localparam logic [15:0] NOP_INSTR  = 16'h0000;

  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_WAIT   = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-4] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+1 and valid. Bubble beats hold,
// hold beats load; reset and bubble both produce an empty slot.
module if_id_reg #(
  parameter int          PC_W      = 16,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic                           hold,
  input  logic                           bubble,
  input  logic [wisc15_pkg::INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]                pc1_in,
  output logic [wisc15_pkg::INSTR_W-1:0] instr,
  output logic [PC_W-1:0]                pc1,
  output logic                           valid
);

  logic [wisc15_pkg::INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]                pc1_q, pc1_d;
  logic                           valid_q, valid_d;

  // Register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc1_q   <= {PC_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  // Next-value select
  always_comb begin
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_INSTR;
      pc1_d   = {PC_W{1'b0}};
      valid_d = 1'b0;
    end else if (hold) begin
      instr_d = instr_q;
      pc1_d   = pc1_q;
      valid_d = valid_q;
    end else if (load) begin
      instr_d = instr_in;
      pc1_d   = pc1_in;
      valid_d = 1'b1;
    end else begin
      instr_d = instr_q;
      pc1_d   = pc1_q;
      valid_d = valid_q;
    end
  end

  assign instr = instr_q;
  assign pc1   = pc1_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// WISC-15 IF stage: owns the PC, drives the instruction-memory read port and
// feeds the IF/ID register, honouring flush, stall, imem wait-states and HLT.
module fetch_stage #(
  parameter int             PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [15:0]    NOP_INSTR = 16'h0000,
  parameter logic [3:0]     OP_HLT    = 4'hF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [15:0]     imem_data,
  input  logic            imem_rdy,
  output logic [15:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc1,
  output logic            if_id_valid,
  output logic            halted
);

  import wisc15_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc_s;
  logic            ifid_load_s, ifid_hold_s, ifid_bubble_s;
  logic            data_is_hlt_s;

  assign pc_inc_s      = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign data_is_hlt_s = (imem_data[15:12] == OP_HLT);

  // PC and fetch-state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-PC mux and FSM; priority is flush > stall > imem wait > advance
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_load_s   = 1'b0;
    ifid_hold_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    case (state_q)
      FS_RUN, FS_WAIT: begin
        if (flush) begin
          pc_d          = br_target;
          ifid_bubble_s = 1'b1;
          state_d       = FS_RUN;
        end else if (stall) begin
          ifid_hold_s = 1'b1;
        end else if (!imem_rdy) begin
          ifid_bubble_s = 1'b1;
          state_d       = FS_WAIT;
        end else begin
          ifid_load_s = 1'b1;
          // HLT freezes the PC on its own address
          if (data_is_hlt_s) begin
            state_d = FS_HALTED;
          end else begin
            pc_d    = pc_inc_s;
            state_d = FS_RUN;
          end
        end
      end
      FS_HALTED: begin
        if (flush) begin
          pc_d          = br_target;
          ifid_bubble_s = 1'b1;
          state_d       = FS_RUN;
        end else if (stall) begin
          ifid_hold_s = 1'b1;
        end else begin
          ifid_bubble_s = 1'b1;
        end
      end
      default: begin
        state_d       = FS_RUN;
        ifid_bubble_s = 1'b1;
      end
    endcase
  end

  if_id_reg #(
    .PC_W      (PC_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load_s),
    .hold     (ifid_hold_s),
    .bubble   (ifid_bubble_s),
    .instr_in (imem_data),
    .pc1_in   (pc_inc_s),
    .instr    (if_id_instr),
    .pc1      (if_id_pc1),
    .valid    (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign imem_rd   = (state_q != FS_HALTED);
  assign halted    = (state_q == FS_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// reset/wait/halt sequences, then random stimulus against a reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, imem_rdy, imem_rd, if_id_valid, halted;
  logic [15:0] br_target, imem_addr, imem_data, if_id_instr, if_id_pc1;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .br_target   (br_target),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_data   (imem_data),
    .imem_rdy    (imem_rdy),
    .if_id_instr (if_id_instr),
    .if_id_pc1   (if_id_pc1),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  typedef struct {
    logic        s;
    logic        f;
    logic [15:0] t;
    logic        r;
    logic [15:0] d;
    logic [15:0] e_addr;
    logic        e_rd;
    logic [15:0] e_instr;
    logic [15:0] e_pc1;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  vec_t vt[23];

  // Reference model: architectural view only (PC, halted flag, IF/ID slot)
  int          m_pc;
  bit          m_halt;
  logic [15:0] m_instr, m_pc1;
  bit          m_valid;

  task automatic model_reset();
    m_pc = 0; m_halt = 0; m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 0;
  endtask

  task automatic model_step(input logic s, f, input logic [15:0] t, input logic r, input logic [15:0] d);
    if (f) begin
      m_pc = int'(t); m_halt = 0; m_instr = 16'h0000; m_valid = 0;
    end else if (s) begin
      // nothing moves
    end else if (m_halt || !r) begin
      m_instr = 16'h0000; m_valid = 0;
    end else begin
      m_instr = d; m_valid = 1; m_pc1 = 16'((m_pc + 1) % 65536);
      if (d[15:12] == 4'hF) m_halt = 1;
      else m_pc = (m_pc + 1) % 65536;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_addr, input logic e_rd,
                         input logic [15:0] e_instr, input logic [15:0] e_pc1,
                         input logic e_valid, input logic e_halted);
    chk({tag, " imem_addr"}, imem_addr, e_addr);
    chk({tag, " imem_rd"}, {15'd0, imem_rd}, {15'd0, e_rd});
    chk({tag, " if_id_instr"}, if_id_instr, e_instr);
    chk({tag, " if_id_valid"}, {15'd0, if_id_valid}, {15'd0, e_valid});
    chk({tag, " halted"}, {15'd0, halted}, {15'd0, e_halted});
    if (e_valid) chk({tag, " if_id_pc1"}, if_id_pc1, e_pc1);
  endtask

  task automatic step(input logic s, f, input logic [15:0] t, input logic r, input logic [15:0] d);
    stall = s; flush = f; br_target = t; imem_rdy = r; imem_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; br_target = 16'h0000;
    imem_rdy = 1'b0; imem_data = 16'h0000;

    //            s     f     target    r     data      addr      rd    instr     pc1       v     h
    vt[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h0001, 1'b1, 16'h1234, 16'h0001, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h2345, 16'h0002, 1'b1, 16'h2345, 16'h0002, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h3456, 16'h0003, 1'b1, 16'h3456, 16'h0003, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0A03, 16'h0004, 1'b1, 16'h0A03, 16'h0004, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0A04, 16'h0005, 1'b1, 16'h0A04, 16'h0005, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0A05, 16'h0005, 1'b1, 16'h0A04, 16'h0005, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0A05, 16'h0005, 1'b1, 16'h0A04, 16'h0005, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0005, 1'b1, 16'h0A04, 16'h0005, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0A05, 16'h0006, 1'b1, 16'h0A05, 16'h0006, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0A06, 16'h0007, 1'b1, 16'h0A06, 16'h0007, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0007, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0007, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0A07, 16'h0008, 1'b1, 16'h0A07, 16'h0008, 1'b1, 1'b0};
    vt[13] = '{1'b1, 1'b1, 16'h0040, 1'b1, 16'h0A08, 16'h0040, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0B40, 16'h0041, 1'b1, 16'h0B40, 16'h0041, 1'b1, 1'b0};
    vt[15] = '{1'b0, 1'b1, 16'h0010, 1'b1, 16'h0B41, 16'h0010, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0010, 1'b0, 16'hF000, 16'h0011, 1'b1, 1'b1};
    vt[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vt[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vt[19] = '{1'b0, 1'b1, 16'h0020, 1'b1, 16'hF000, 16'h0020, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[20] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0C20, 16'h0021, 1'b1, 16'h0C20, 16'h0021, 1'b1, 1'b0};
    vt[21] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[22] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0DDD, 16'h0000, 1'b1, 16'h0DDD, 16'h0000, 1'b1, 1'b0};

    @(posedge clk);
    #2;
    chk_all("reset", 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("reset if_id_pc1", if_id_pc1, 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(vt[i].s, vt[i].f, vt[i].t, vt[i].r, vt[i].d);
      chk_all($sformatf("tbl%0d", i), vt[i].e_addr, vt[i].e_rd, vt[i].e_instr,
              vt[i].e_pc1, vt[i].e_valid, vt[i].e_halted);
    end

    // Async reset in the middle of a wait-state sequence
    step(1'b0, 1'b1, 16'h0033, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk_all("wait33", 16'h0033, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst_wait", 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("rst_wait if_id_pc1", if_id_pc1, 16'h0000);
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
    chk_all("resume", 16'h0001, 1'b1, 16'h1111, 16'h0001, 1'b1, 1'b0);

    // Stall in WAIT with data present: data dropped, fetch re-issued
    step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h2222);
    chk_all("wait_stall", 16'h0001, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333);
    chk_all("wait_done", 16'h0002, 1'b1, 16'h3333, 16'h0002, 1'b1, 1'b0);

    // HLT held under stall, then async reset clears halted
    step(1'b0, 1'b0, 16'h0000, 1'b1, 16'hF123);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000);
    chk_all("hlt_stall", 16'h0002, 1'b0, 16'hF123, 16'h0003, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
    chk_all("hlt_bubble", 16'h0002, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst_halt", 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic        s, f, r;
      logic [15:0] t, d;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 2) != 0);
      t = 16'($urandom);
      d = 16'($urandom);
      step(s, f, t, r, d);
      model_step(s, f, t, r, d);
      chk_all($sformatf("rnd%0d", n), 16'(m_pc), !m_halt, m_instr, m_pc1, m_valid, m_halt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
